// File: rtl/clock_timekeeper.sv
// Real-time clock with seconds prescaler, button-driven set mode and BCD display output.
// Define CLOCK_12H_EN to show hours in 12-hour form with an afternoon indicator on pm.
module clock_timekeeper #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [31:0] bcd_time,
  output logic        dot_clk,
  output logic        turn_on,
  output logic        clock_mode,
  output logic        pm
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          dot_clk_q, dot_clk_d;
  logic          turn_on_q, turn_on_d;
  logic          pm_q, pm_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [4:0]    disp_hr;
  logic          tick;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;

    case (state_q)
      RUN: begin
        if (tick) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d = 6'd0;
              hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (btn_mode) state_d = SET_HR;
      end
      SET_HR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
        end else if (btn_inc) begin
          hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end
      end
      SET_MIN: begin
        // Leaving set mode restarts the second from a clean boundary.
        if (btn_mode) begin
          state_d = RUN;
          sec_d   = 6'd0;
          presc_d = '0;
        end else if (btn_inc) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: state_d = RUN;
    endcase

    dot_clk_d = (presc_d < PRESC_HALF);
    turn_on_d = (state_d == RUN) ? 1'b1 : dot_clk_d;

`ifdef CLOCK_12H_EN
    if (hr_d == 5'd0) begin
      disp_hr = 5'd12;
    end else if (hr_d > 5'd12) begin
      disp_hr = hr_d - 5'd12;
    end else begin
      disp_hr = hr_d;
    end
    pm_d = (hr_d >= 5'd12);
`else
    disp_hr = hr_d;
    pm_d    = 1'b0;
`endif

    bcd_d = {to_bcd({1'b0, disp_hr}), 4'h0, to_bcd(min_d), 4'h0, to_bcd(sec_d)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      presc_q   <= '0;
      hr_q      <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      dot_clk_q <= 1'b1;
      turn_on_q <= 1'b1;
      pm_q      <= 1'b0;
      bcd_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      dot_clk_q <= dot_clk_d;
      turn_on_q <= turn_on_d;
      pm_q      <= pm_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bcd_time   = bcd_q;
  assign dot_clk    = dot_clk_q;
  assign turn_on    = turn_on_q;
  assign clock_mode = 1'b1;
  assign pm         = pm_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Randomized bench for clock_timekeeper: a seconds-of-day reference model checks
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_clock_timekeeper;

  localparam int CLK_FREQ = 10;

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HR_ZERO = 8'h12;
  localparam logic [31:0] T_235959 = 32'h11059059;
  localparam logic [31:0] T_MIDNIGHT = 32'h12000000;
`else
  localparam logic [7:0] HR_ZERO = 8'h00;
  localparam logic [31:0] T_235959 = 32'h23059059;
  localparam logic [31:0] T_MIDNIGHT = 32'h00000000;
`endif

  logic        clk;
  logic        reset;
  logic        btn_mode;
  logic        btn_inc;
  logic [31:0] bcd_time;
  logic        dot_clk;
  logic        turn_on;
  logic        clock_mode;
  logic        pm;

  int checks = 0;
  int errors = 0;

  // Reference model: time of day as a plain second count, prescaler phase, mode 0/1/2
  int  m_secs  = 0;
  int  m_phase = 0;
  int  m_mode  = 0;
  bit  m_valid = 0;

  clock_timekeeper #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .bcd_time  (bcd_time),
    .dot_clk   (dot_clk),
    .turn_on   (turn_on),
    .clock_mode(clock_mode),
    .pm        (pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] two_digits(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] model_bcd();
    int h, hd;
    h = m_secs / 3600;
`ifdef CLOCK_12H_EN
    hd = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
`else
    hd = h;
`endif
    return {two_digits(hd), 4'h0, two_digits((m_secs / 60) % 60), 4'h0, two_digits(m_secs % 60)};
  endfunction

  function automatic logic model_pm();
`ifdef CLOCK_12H_EN
    return (m_secs / 3600) >= 12;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit tick;
    int h, m;
    if (reset) begin
      m_secs  = 0;
      m_phase = 0;
      m_mode  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      tick    = (m_phase == CLK_FREQ - 1);
      m_phase = (m_phase + 1) % CLK_FREQ;
      case (m_mode)
        0: begin
          if (tick) m_secs = (m_secs + 1) % 86400;
          if (btn_mode) m_mode = 1;
        end
        1: begin
          if (btn_mode) m_mode = 2;
          else if (btn_inc) begin
            h = m_secs / 3600;
            m_secs = m_secs - h * 3600 + ((h + 1) % 24) * 3600;
          end
        end
        default: begin
          if (btn_mode) begin
            m_mode  = 0;
            m_secs  = m_secs - (m_secs % 60);
            m_phase = 0;
          end else if (btn_inc) begin
            m = (m_secs / 60) % 60;
            m_secs = m_secs + (((m + 1) % 60) - m) * 60;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic exp_dot;
    if (m_valid) begin
      exp_dot = (m_phase < CLK_FREQ / 2);
      checkOutput("bcd_time", bcd_time, model_bcd());
      checkOutput("dot_clk", {31'b0, dot_clk}, {31'b0, exp_dot});
      checkOutput("turn_on", {31'b0, turn_on}, {31'b0, (m_mode == 0) ? 1'b1 : exp_dot});
      checkOutput("pm", {31'b0, pm}, {31'b0, model_pm()});
      checkOutput("clock_mode", {31'b0, clock_mode}, 32'd1);
    end
  end

  task automatic applyStimulus(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pressInc(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    int hi_cnt, r;
    bit found;
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_bcd", bcd_time, {HR_ZERO, 24'h0});
    checkOutput("reset_turn_on", {31'b0, turn_on}, 32'd1);
    checkOutput("reset_dot", {31'b0, dot_clk}, 32'd1);
    checkOutput("reset_pm", {31'b0, pm}, 32'd0);

    // Tick coincident with btn_mode in RUN, then simultaneous buttons in SET_HR
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_phase == CLK_FREQ - 1) found = 1;
      else @(negedge clk);
    end
    checkOutput("wait_tick_phase", {31'b0, found}, 32'd1);
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    checkOutput("tick_and_mode", bcd_time, {HR_ZERO, 24'h000001});
    applyStimulus(1'b0, 1'b1);
    checkOutput("set_hr_inc", bcd_time, 32'h01000001);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mode_over_inc", bcd_time, 32'h01000001);
    applyStimulus(1'b0, 1'b1);
    checkOutput("set_min_inc", bcd_time, 32'h01001001);
    applyStimulus(1'b1, 1'b0);
    checkOutput("exit_clears_sec", bcd_time, 32'h01001000);

    // Set mode: 5 hours, 61 minute presses wrap without carry
    doReset();
    applyStimulus(1'b1, 1'b0);
    pressInc(5);
    applyStimulus(1'b1, 1'b0);
    pressInc(61);
    applyStimulus(1'b1, 1'b0);
    checkOutput("set_0501", bcd_time, 32'h05001000);

    // Blink in SET_HR, steady in RUN
    applyStimulus(1'b1, 1'b0);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (turn_on) hi_cnt++;
    end
    checkOutput("blink_high_count", hi_cnt, 10);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (turn_on) hi_cnt++;
    end
    checkOutput("run_steady_on", hi_cnt, 20);

    // Rollover from 23:59:00
    doReset();
    applyStimulus(1'b1, 1'b0);
    pressInc(23);
    applyStimulus(1'b1, 1'b0);
    pressInc(59);
    applyStimulus(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 700 && !found; k++) begin
      @(negedge clk);
      if (bcd_time === T_235959) found = 1;
    end
    checkOutput("reach_235959", {31'b0, found}, 32'd1);
    found = 0;
    for (int k = 0; k < CLK_FREQ + 1 && !found; k++) begin
      @(negedge clk);
      if (bcd_time !== T_235959) found = 1;
    end
    checkOutput("midnight_wrap", bcd_time, T_MIDNIGHT);

`ifdef CLOCK_12H_EN
    doReset();
    applyStimulus(1'b1, 1'b0);
    pressInc(13);
    checkOutput("h13_digits", {24'h0, bcd_time[31:24]}, 32'h01);
    checkOutput("h13_pm", {31'b0, pm}, 32'd1);
    pressInc(11);
    checkOutput("h0_digits", {24'h0, bcd_time[31:24]}, 32'h12);
    checkOutput("h0_pm", {31'b0, pm}, 32'd0);
`endif

    // Randomized buttons with occasional reset
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      r = $urandom_range(0, 199);
      reset    = (r < 2);
      btn_mode = (r >= 2 && r < 14) || (r == 199);
      btn_inc  = (r >= 14 && r < 80) || (r == 199) || (r == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
